// File: rtl/mac_operand_feeder_pkg.sv
// mac_operand_feeder_pkg
// Shared definitions for the MAC operand feeder:
//   - the feeder FSM state encoding
//   - the default buffer depth and MAC completion timeout
//   - operand, result and pair-count widths
// No ports; imported by the interface, the pair buffer and the top.

package mac_operand_feeder_pkg;

  localparam int DEF_DEPTH   = 16;  // operand pairs held per job (max 31)
  localparam int DEF_TIMEOUT = 64;  // cycles to wait for mac_finish
  localparam int OP_W        = 8;   // signed operand width
  localparam int RES_W       = 16;  // signed MAC result width
  localparam int CNT_W       = 5;   // width of fill / index / pair counts

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// mac_operand_feeder_if
// Bundles every non-clock signal of the feeder:
//   write channel : wr_valid, wr_ready, wr_a, wr_b
//   control       : go, busy
//   MAC side      : mac_start, mac_count, mac_opA, mac_opB, mac_finish, mac_out
//   result channel: res_valid, res_ready, res_data, res_len, res_err
// Modports:
//   master - the feeder itself
//   slave  - whatever surrounds it (producer, MAC and result consumer)

interface mac_operand_feeder_if;
  import mac_operand_feeder_pkg::*;

  logic                    wr_valid;
  logic                    wr_ready;
  logic signed [OP_W-1:0]  wr_a;
  logic signed [OP_W-1:0]  wr_b;

  logic                    go;
  logic                    busy;

  logic                    mac_start;
  logic [CNT_W-1:0]        mac_count;
  logic signed [OP_W-1:0]  mac_opA;
  logic signed [OP_W-1:0]  mac_opB;
  logic                    mac_finish;
  logic signed [RES_W-1:0] mac_out;

  logic                    res_valid;
  logic                    res_ready;
  logic signed [RES_W-1:0] res_data;
  logic [CNT_W-1:0]        res_len;
  logic                    res_err;

  modport master (
    input  wr_valid, wr_a, wr_b, go, mac_finish, mac_out, res_ready,
    output wr_ready, busy, mac_start, mac_count, mac_opA, mac_opB,
           res_valid, res_data, res_len, res_err
  );

  modport slave (
    output wr_valid, wr_a, wr_b, go, mac_finish, mac_out, res_ready,
    input  wr_ready, busy, mac_start, mac_count, mac_opA, mac_opB,
           res_valid, res_data, res_len, res_err
  );

endinterface

// File: rtl/mac_pair_buffer.sv
// mac_pair_buffer
// Operand-pair storage: one write port and one indexed read port, both
// synchronous. Contents are never reset; the feeder tracks validity with
// its own fill count.
// Ports:
//   clk        - clock
//   we         - write enable
//   waddr      - write address
//   wa, wb     - operand pair to store
//   raddr      - read address
//   ra, rb     - registered read data (pair at raddr as of the last edge)

module mac_pair_buffer
  import mac_operand_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic signed [OP_W-1:0] wa,
  input  logic signed [OP_W-1:0] wb,
  input  logic [AW-1:0]          raddr,
  output logic signed [OP_W-1:0] ra,
  output logic signed [OP_W-1:0] rb
);

  logic [2*OP_W-1:0] mem [DEPTH];
  logic [2*OP_W-1:0] rd_reg;

  // Write-first: a pair written to the address being read is returned on
  // the same edge. The feeder relies on this when the first pair of a job
  // arrives in the same cycle as go.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= {wa, wb};
    end
    if (we && (waddr == raddr)) begin
      rd_reg <= {wa, wb};
    end else begin
      rd_reg <= mem[raddr];
    end
  end

  assign ra = rd_reg[2*OP_W-1:OP_W];
  assign rb = rd_reg[OP_W-1:0];

endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
// Collects signed operand pairs into a buffer, then on go streams them to
// a MAC one pair per cycle, waits (with timeout) for the MAC result and
// presents it on a valid/ready result channel.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - mac_operand_feeder_if.master: write channel, go/busy, MAC
//             stream and completion, result channel

module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mac_operand_feeder_if.master bus
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [WCW-1:0]   WAIT_MAX = WCW'(TIMEOUT - 1);

  state_t                  state_reg,    state_next;
  logic [CNT_W-1:0]        fill_reg,     fill_next;
  logic [CNT_W-1:0]        idx_reg,      idx_next;
  logic [WCW-1:0]          wait_reg,     wait_next;
  logic signed [RES_W-1:0] res_data_reg, res_data_next;
  logic [CNT_W-1:0]        res_len_reg,  res_len_next;
  logic                    res_err_reg,  res_err_next;

  logic                    wr_fire;
  logic [CNT_W-1:0]        idx_plus1;
  logic [CNT_W-1:0]        rd_addr;
  logic signed [OP_W-1:0]  buf_a;
  logic signed [OP_W-1:0]  buf_b;

  assign wr_fire   = (state_reg == LOAD) && bus.wr_valid && (fill_reg < DEPTH_C);
  assign idx_plus1 = idx_reg + ONE_C;

  mac_pair_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (fill_reg[AW-1:0]),
    .wa    (bus.wr_a),
    .wb    (bus.wr_b),
    .raddr (rd_addr[AW-1:0]),
    .ra    (buf_a),
    .rb    (buf_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= LOAD;
      fill_reg     <= '0;
      idx_reg      <= '0;
      wait_reg     <= '0;
      res_data_reg <= '0;
      res_len_reg  <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_reg     <= fill_next;
      idx_reg      <= idx_next;
      wait_reg     <= wait_next;
      res_data_reg <= res_data_next;
      res_len_reg  <= res_len_next;
      res_err_reg  <= res_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_next     = fill_reg;
    idx_next      = idx_reg;
    wait_next     = wait_reg;
    res_data_next = res_data_reg;
    res_len_next  = res_len_reg;
    res_err_next  = res_err_reg;
    rd_addr       = '0;

    unique case (state_reg)
      LOAD: begin
        // Keep pair 0 prefetched so it is on the read port in the first
        // STREAM cycle.
        rd_addr = '0;
        if (wr_fire) begin
          fill_next = fill_reg + ONE_C;
        end
        if (bus.go && ((fill_reg != '0) || wr_fire)) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end

      STREAM: begin
        // The read port is one cycle behind its address, so fetch the pair
        // for the next STREAM cycle now.
        rd_addr = (idx_plus1 < fill_reg) ? idx_plus1 : '0;
        if (idx_reg == fill_reg - ONE_C) begin
          state_next = WAIT;
          wait_next  = '0;
        end else begin
          idx_next = idx_plus1;
        end
      end

      WAIT: begin
        if (bus.mac_finish) begin
          state_next    = RESULT;
          res_data_next = bus.mac_out;
          res_len_next  = fill_reg;
          res_err_next  = 1'b0;
        end else if (wait_reg == WAIT_MAX) begin
          state_next    = RESULT;
          res_data_next = '0;
          res_len_next  = fill_reg;
          res_err_next  = 1'b1;
        end else begin
          wait_next = wait_reg + WCW'(1);
        end
      end

      RESULT: begin
        if (bus.res_ready) begin
          state_next = LOAD;
          fill_next  = '0;
          idx_next   = '0;
        end
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

  assign bus.wr_ready  = (state_reg == LOAD) && (fill_reg < DEPTH_C);
  assign bus.busy      = (state_reg != LOAD);
  assign bus.mac_start = (state_reg == STREAM) && (idx_reg == '0);
  assign bus.mac_count = ((state_reg == STREAM) || (state_reg == WAIT)) ? fill_reg : '0;
  assign bus.mac_opA   = (state_reg == STREAM) ? buf_a : '0;
  assign bus.mac_opB   = (state_reg == STREAM) ? buf_b : '0;
  assign bus.res_valid = (state_reg == RESULT);
  assign bus.res_data  = res_data_reg;
  assign bus.res_len   = res_len_reg;
  assign bus.res_err   = res_err_reg;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder
// Directed bench for mac_operand_feeder: loads operand pairs, streams
// jobs, returns MAC results or lets the wait time out, exercises result
// back-pressure and reset in the middle of a job.

module tb_mac_operand_feeder;
  import mac_operand_feeder_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  mac_operand_feeder_if bus ();

  mac_operand_feeder #(
    .DEPTH   (16),
    .TIMEOUT (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_mac_start"}, bus.mac_start, 0);
    chk({tag, "_mac_count"}, bus.mac_count, 0);
    chk({tag, "_opA"},       bus.mac_opA,   0);
    chk({tag, "_opB"},       bus.mac_opB,   0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"},  bus.res_data,  0);
    chk({tag, "_res_len"},   bus.res_len,   0);
    chk({tag, "_res_err"},   bus.res_err,   0);
    chk({tag, "_wr_ready"},  bus.wr_ready,  1);
  endtask

  task automatic write_pair(input string tag, input int a, input int b);
    bus.wr_valid = 1'b1;
    bus.wr_a     = 8'(a);
    bus.wr_b     = 8'(b);
    chk({tag, "_wr_ready"}, bus.wr_ready, 1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_a        = '0;
    bus.wr_b        = '0;
    bus.go          = 1'b0;
    bus.mac_finish  = 1'b0;
    bus.mac_out     = '0;
    bus.res_ready   = 1'b0;

    // Reset state
    step();
    step();
    chk_reset_values("rst");
    reset_n = 1'b1;
    step();
    chk_reset_values("post_rst");

    // Job 1: three pairs, MAC returns 19
    write_pair("j1_w0", 3, 4);
    write_pair("j1_w1", -2, 5);
    write_pair("j1_w2", 7, -1);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("j1_start0", bus.mac_start, 1);
    chk("j1_count0", bus.mac_count, 3);
    chk("j1_busy",   bus.busy,      1);
    chk("j1_wrrdy",  bus.wr_ready,  0);
    chk("j1_a0",     bus.mac_opA,   3);
    chk("j1_b0",     bus.mac_opB,   4);
    step();
    chk("j1_start1", bus.mac_start, 0);
    chk("j1_a1",     bus.mac_opA,   -2);
    chk("j1_b1",     bus.mac_opB,   5);
    step();
    chk("j1_a2",     bus.mac_opA,   7);
    chk("j1_b2",     bus.mac_opB,   -1);
    chk("j1_count2", bus.mac_count, 3);
    step();
    chk("j1_wait_a",     bus.mac_opA,   0);
    chk("j1_wait_start", bus.mac_start, 0);
    chk("j1_wait_count", bus.mac_count, 3);
    chk("j1_wait_valid", bus.res_valid, 0);
    bus.mac_finish = 1'b1;
    bus.mac_out    = 16'sd19;
    step();
    bus.mac_finish = 1'b0;
    chk("j1_res_valid", bus.res_valid, 1);
    chk("j1_res_data",  bus.res_data,  19);
    chk("j1_res_len",   bus.res_len,   3);
    chk("j1_res_err",   bus.res_err,   0);
    chk("j1_res_count", bus.mac_count, 0);
    $display("job1: len=%0d data=%0d err=%0d", bus.res_len, bus.res_data, bus.res_err);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j1_done_valid", bus.res_valid, 0);
    chk("j1_done_busy",  bus.busy,      0);

    // Job 2: full buffer, 17th write dropped
    for (int i = 0; i < 16; i++) begin
      write_pair("j2_w", i, 100 - i);
    end
    bus.wr_valid = 1'b1;
    bus.wr_a     = 8'sd55;
    bus.wr_b     = 8'sd55;
    chk("j2_full_wrrdy", bus.wr_ready, 0);
    step();
    bus.wr_valid = 1'b0;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("j2_start", bus.mac_start, (i == 0) ? 1 : 0);
      chk("j2_count", bus.mac_count, 16);
      chk("j2_a",     bus.mac_opA,   i);
      chk("j2_b",     bus.mac_opB,   100 - i);
      step();
    end
    chk("j2_wait_a",     bus.mac_opA,   0);
    chk("j2_wait_count", bus.mac_count, 16);
    bus.mac_finish = 1'b1;
    bus.mac_out    = -16'sd300;
    step();
    bus.mac_finish = 1'b0;
    chk("j2_res_data", bus.res_data, -300);
    chk("j2_res_len",  bus.res_len,  16);
    chk("j2_res_err",  bus.res_err,  0);
    $display("job2: len=%0d data=%0d err=%0d", bus.res_len, bus.res_data, bus.res_err);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // go with empty buffer is ignored
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("empty_go_busy",  bus.busy,      0);
    chk("empty_go_start", bus.mac_start, 0);
    step();
    chk("empty_go_busy2", bus.busy, 0);

    // Job 3: write and go in the same cycle -> one-pair job, then timeout
    bus.wr_valid = 1'b1;
    bus.wr_a     = -8'sd7;
    bus.wr_b     = 8'sd9;
    bus.go       = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.go       = 1'b0;
    chk("j3_start", bus.mac_start, 1);
    chk("j3_count", bus.mac_count, 1);
    chk("j3_a",     bus.mac_opA,   -7);
    chk("j3_b",     bus.mac_opB,   9);
    step();
    chk("j3_wait_count", bus.mac_count, 1);
    chk("j3_wait_start", bus.mac_start, 0);
    for (int i = 0; i < 63; i++) begin
      step();
    end
    chk("j3_prets_valid", bus.res_valid, 0);
    chk("j3_prets_busy",  bus.busy,      1);
    step();
    chk("j3_to_valid", bus.res_valid, 1);
    chk("j3_to_err",   bus.res_err,   1);
    chk("j3_to_data",  bus.res_data,  0);
    $display("job3: len=%0d data=%0d err=%0d", bus.res_len, bus.res_data, bus.res_err);

    // Result held under back-pressure; stray mac_finish and go ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus.mac_finish = 1'b1;
        bus.mac_out    = 16'sd123;
        bus.go         = 1'b1;
      end else begin
        bus.mac_finish = 1'b0;
        bus.go         = 1'b0;
      end
      step();
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data",  bus.res_data,  0);
      chk("hold_err",   bus.res_err,   1);
    end
    bus.mac_finish = 1'b0;
    bus.go         = 1'b0;
    bus.res_ready  = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("hold_done_valid",  bus.res_valid, 0);
    chk("hold_done_busy",   bus.busy,      0);
    chk("hold_done_wrrdy",  bus.wr_ready,  1);
    // fill must be 0 again, so go alone stays idle
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("hold_fill_cleared", bus.busy, 0);

    // Job 4: reset at idx 2 of a 5-pair job
    write_pair("j4_w0", 10, 1);
    write_pair("j4_w1", 20, 2);
    write_pair("j4_w2", 30, 3);
    write_pair("j4_w3", 40, 4);
    write_pair("j4_w4", 50, 5);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("j4_a0", bus.mac_opA, 10);
    step();
    chk("j4_a1", bus.mac_opA, 20);
    step();
    chk("j4_a2", bus.mac_opA, 30);
    chk("j4_b2", bus.mac_opB, 3);
    reset_n = 1'b0;
    step();
    chk_reset_values("mid_rst");
    reset_n = 1'b1;
    step();
    chk_reset_values("mid_rst_rel");

    // Job 5: fresh job after reset
    write_pair("j5_w0", -128, 127);
    write_pair("j5_w1", 5, -6);
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    chk("j5_start0", bus.mac_start, 1);
    chk("j5_count",  bus.mac_count, 2);
    chk("j5_a0",     bus.mac_opA,   -128);
    chk("j5_b0",     bus.mac_opB,   127);
    step();
    chk("j5_start1", bus.mac_start, 0);
    chk("j5_a1",     bus.mac_opA,   5);
    chk("j5_b1",     bus.mac_opB,   -6);
    step();
    bus.mac_finish = 1'b1;
    bus.mac_out    = -16'sd1;
    step();
    bus.mac_finish = 1'b0;
    chk("j5_res_valid", bus.res_valid, 1);
    chk("j5_res_data",  bus.res_data,  -1);
    chk("j5_res_len",   bus.res_len,   2);
    chk("j5_res_err",   bus.res_err,   0);
    $display("job5: len=%0d data=%0d err=%0d", bus.res_len, bus.res_data, bus.res_err);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j5_done_valid", bus.res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
